// File: rtl/multi_duck_game_logic.sv
// multi_duck_game_logic
// Shooting-game controller for N_DUCKS simultaneous targets. Tracks the
// magazine, the reserve rounds and the kill score, and sequences the
// IDLE -> COUNTDOWN -> HUNTING <-> RELOAD / DEATH -> GAME_OVER flow.
//
// Ports
//   clk, rst            : clock (posedge) and synchronous active-high reset
//   game_enable         : level; low forces IDLE and reloads all counters
//   mouse_xpos/ypos     : cursor position (12 bit each)
//   left_mouse          : fire button level (edge-detected internally)
//   right_mouse         : reload button level (edge-detected internally)
//   duck_xpos/ypos      : packed top-left corners, duck i at [12i+11:12i]
//   duck_active         : duck i alive and on screen
//   bullets_in_magazine : rounds in the magazine
//   bullets_left        : reserve rounds
//   my_score            : saturating kill count
//   hunt_start          : high in HUNTING and RELOAD
//   show_reload_char    : magazine empty while not IDLE
//   duck_killed         : one-hot victim, held through DEATH
//   dog_bird_enable     : single-cycle pulse while the DEATH timer == DOG_CYC
//   game_over           : high in GAME_OVER
module multi_duck_game_logic #(
    parameter int N_DUCKS       = 2,
    parameter int DUCK_W        = 96,
    parameter int DUCK_H        = 60,
    parameter int MAG_SIZE      = 3,
    parameter int AMMO_TOTAL    = 27,
    parameter int SCORE_W       = 7,
    parameter int COUNTDOWN_CYC = 520_000_000,
    parameter int DEATH_CYC     = 390_000_000,
    parameter int DOG_CYC       = 260_000_000,
    parameter int RELOAD_CYC    = 32_500_000,
    parameter int MAG_W         = $clog2(MAG_SIZE + 1),
    parameter int AMMO_W        = $clog2(AMMO_TOTAL + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   game_enable,
    input  logic [11:0]            mouse_xpos,
    input  logic [11:0]            mouse_ypos,
    input  logic                   left_mouse,
    input  logic                   right_mouse,
    input  logic [12*N_DUCKS-1:0]  duck_xpos,
    input  logic [12*N_DUCKS-1:0]  duck_ypos,
    input  logic [N_DUCKS-1:0]     duck_active,
    output logic [MAG_W-1:0]       bullets_in_magazine,
    output logic [AMMO_W-1:0]      bullets_left,
    output logic [SCORE_W-1:0]     my_score,
    output logic                   hunt_start,
    output logic                   show_reload_char,
    output logic [N_DUCKS-1:0]     duck_killed,
    output logic                   dog_bird_enable,
    output logic                   game_over
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_COUNTDOWN = 3'd1,
        S_HUNTING   = 3'd2,
        S_RELOAD    = 3'd3,
        S_DEATH     = 3'd4,
        S_GAME_OVER = 3'd5
    } state_t;

    state_t               state_r, state_n;
    logic [31:0]          timer_r, timer_n;
    logic [MAG_W-1:0]     mag_r, mag_n;
    logic [AMMO_W-1:0]    ammo_r, ammo_n;
    logic [SCORE_W-1:0]   score_r, score_n;
    logic [N_DUCKS-1:0]   killed_r, killed_n;
    logic                 left_prev_r, right_prev_r;
    logic                 hunt_r, reload_char_r, dog_r, over_r;
    logic                 hunt_s, reload_char_s, dog_s, over_s;
    logic                 left_edge_s, right_edge_s;
    logic [N_DUCKS-1:0]   in_box_s, hit_s;
    logic [31:0]          need_s, take_s;

    // Inclusive hitbox test; operands are widened to 13 bits so dx+DUCK_W
    // cannot wrap near the right/bottom screen edge.
    function automatic logic in_box(input logic [11:0] px, input logic [11:0] py,
                                    input logic [11:0] dx, input logic [11:0] dy);
        logic [12:0] px_w, py_w, dx_w, dy_w;
        px_w = {1'b0, px};
        py_w = {1'b0, py};
        dx_w = {1'b0, dx};
        dy_w = {1'b0, dy};
        in_box = (px_w >= dx_w) && (px_w <= (dx_w + 13'(DUCK_W))) &&
                 (py_w >= dy_w) && (py_w <= (dy_w + 13'(DUCK_H)));
    endfunction

    // A held button yields exactly one edge: compare against last cycle's level.
    assign left_edge_s  = left_mouse & ~left_prev_r;
    assign right_edge_s = right_mouse & ~right_prev_r;

    // Rounds moved on reload completion: min(free slots, reserve).
    assign need_s = 32'(MAG_SIZE) - 32'(mag_r);
    assign take_s = (need_s < 32'(ammo_r)) ? need_s : 32'(ammo_r);

    // Per-duck hit test, then isolate the lowest set bit so the lowest index wins.
    always_comb begin
        in_box_s = '0;
        for (int i = 0; i < N_DUCKS; i++) begin
            in_box_s[i] = duck_active[i] &
                          in_box(mouse_xpos, mouse_ypos,
                                 duck_xpos[12*i +: 12], duck_ypos[12*i +: 12]);
        end
        hit_s = in_box_s & (~in_box_s + N_DUCKS'(1));
    end

    // Next-state and next-counter logic.
    always_comb begin
        state_n  = state_r;
        timer_n  = timer_r;
        mag_n    = mag_r;
        ammo_n   = ammo_r;
        score_n  = score_r;
        killed_n = killed_r;
        if (!game_enable) begin
            state_n  = S_IDLE;
            timer_n  = 32'(COUNTDOWN_CYC);
            mag_n    = MAG_W'(MAG_SIZE);
            ammo_n   = AMMO_W'(AMMO_TOTAL);
            score_n  = '0;
            killed_n = '0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    timer_n  = 32'(COUNTDOWN_CYC);
                    mag_n    = MAG_W'(MAG_SIZE);
                    ammo_n   = AMMO_W'(AMMO_TOTAL);
                    score_n  = '0;
                    killed_n = '0;
                    state_n  = S_COUNTDOWN;
                end
                S_COUNTDOWN: begin
                    if (timer_r == 32'd0) begin
                        state_n = S_HUNTING;
                    end else begin
                        timer_n = timer_r - 32'd1;
                    end
                end
                S_HUNTING: begin
                    // A shot takes priority over a reload edge in the same cycle.
                    if (left_edge_s && (mag_r != '0)) begin
                        mag_n = mag_r - MAG_W'(1);
                        if (hit_s != '0) begin
                            if (&score_r) begin
                                score_n = score_r;
                            end else begin
                                score_n = score_r + SCORE_W'(1);
                            end
                            killed_n = hit_s;
                            timer_n  = 32'(DEATH_CYC);
                            state_n  = S_DEATH;
                        end else if ((mag_r == MAG_W'(1)) && (ammo_r == '0)) begin
                            state_n = S_GAME_OVER;
                        end else begin
                            state_n = S_HUNTING;
                        end
                    end else if (right_edge_s && (32'(mag_r) < 32'(MAG_SIZE)) &&
                                 (ammo_r != '0)) begin
                        timer_n = 32'(RELOAD_CYC);
                        state_n = S_RELOAD;
                    end else begin
                        state_n = S_HUNTING;
                    end
                end
                S_RELOAD: begin
                    if (timer_r == 32'd0) begin
                        mag_n   = mag_r + MAG_W'(take_s);
                        ammo_n  = ammo_r - AMMO_W'(take_s);
                        state_n = S_HUNTING;
                    end else begin
                        timer_n = timer_r - 32'd1;
                    end
                end
                S_DEATH: begin
                    if (timer_r == 32'd0) begin
                        killed_n = '0;
                        if ((mag_r == '0) && (ammo_r == '0)) begin
                            state_n = S_GAME_OVER;
                        end else begin
                            state_n = S_HUNTING;
                        end
                    end else begin
                        timer_n = timer_r - 32'd1;
                    end
                end
                S_GAME_OVER: begin
                    state_n = S_GAME_OVER;
                end
                default: begin
                    state_n = S_IDLE;
                end
            endcase
        end
    end

    // Status flags are derived from next-state values so that, once
    // registered, they line up with the state/counter registers.
    assign hunt_s        = (state_n == S_HUNTING) || (state_n == S_RELOAD);
    assign reload_char_s = (mag_n == '0) && (state_n != S_IDLE);
    assign dog_s         = (state_n == S_DEATH) && (timer_n == 32'(DOG_CYC));
    assign over_s        = (state_n == S_GAME_OVER);

    // State, counter, edge-history and output-flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= S_IDLE;
            timer_r       <= 32'(COUNTDOWN_CYC);
            mag_r         <= MAG_W'(MAG_SIZE);
            ammo_r        <= AMMO_W'(AMMO_TOTAL);
            score_r       <= '0;
            killed_r      <= '0;
            left_prev_r   <= 1'b0;
            right_prev_r  <= 1'b0;
            hunt_r        <= 1'b0;
            reload_char_r <= 1'b0;
            dog_r         <= 1'b0;
            over_r        <= 1'b0;
        end else begin
            state_r       <= state_n;
            timer_r       <= timer_n;
            mag_r         <= mag_n;
            ammo_r        <= ammo_n;
            score_r       <= score_n;
            killed_r      <= killed_n;
            left_prev_r   <= left_mouse;
            right_prev_r  <= right_mouse;
            hunt_r        <= hunt_s;
            reload_char_r <= reload_char_s;
            dog_r         <= dog_s;
            over_r        <= over_s;
        end
    end

    assign bullets_in_magazine = mag_r;
    assign bullets_left        = ammo_r;
    assign my_score            = score_r;
    assign duck_killed         = killed_r;
    assign hunt_start          = hunt_r;
    assign show_reload_char    = reload_char_r;
    assign dog_bird_enable     = dog_r;
    assign game_over           = over_r;

endmodule
